// File: rtl/carpark_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carpark_pkg
// Description : Shared types and constants for the car-park exit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package carpark_pkg;

    // Exit controller FSM states (S_LOCK only reachable with lockout enabled)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SEARCH = 3'd2,
        S_OPEN   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5,
        S_LOCK   = 3'd6
    } state_t;

    // Error codes reported on exit_err
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_PSWD     = 2'd1;
    localparam logic [1:0] ERR_NOTFOUND = 2'd2;
    localparam logic [1:0] ERR_LOCK     = 2'd3;

    localparam logic [3:0] DEFAULT_PASSWORD = 4'b1010;

    // Length of the lockout window after repeated bad passwords
    localparam int LOCK_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carpark_slot_table.sv
`default_nettype none
// ============================================================================
// Module      : carpark_slot_table
// Description : Slot occupancy table: vehicle-number array, valid bits,
//               lowest-free slot allocation, occupancy/full/empty and a
//               single-slot read/clear port used by the exit search.
// Revision    : 1.0 - initial release
// ============================================================================
module carpark_slot_table
    import carpark_pkg::*;
#(
    parameter  int N_SLOTS = 16,
    parameter  int VN_W    = 4,
    localparam int SLOT_W  = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [VN_W-1:0]   wr_vn,
    input  logic [SLOT_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic [VN_W-1:0]   rd_vn,
    input  logic              clr_en,
    input  logic [SLOT_W-1:0] clr_idx,
    output logic [SLOT_W:0]   occupancy,
    output logic              full,
    output logic              empty
);

    logic [N_SLOTS-1:0] valid;
    logic [VN_W-1:0]    vn_mem [N_SLOTS];
    logic [SLOT_W-1:0]  free_idx;
    logic               do_write;

    // Lowest-index invalid slot, taken from the pre-edge valid bits so a slot
    // being freed this cycle is never reused in the same cycle
    always_comb begin
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Population count of the valid bits
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            occupancy = occupancy + (SLOT_W+1)'(valid[i]);
        end
    end

    assign full     = (occupancy == (SLOT_W+1)'(N_SLOTS));
    assign empty    = (occupancy == '0);
    assign do_write = wr_en && !full;
    assign rd_valid = valid[rd_idx];
    assign rd_vn    = vn_mem[rd_idx];

    // Valid bits: clear of the matched slot and allocation of a free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (clr_en) begin
                valid[clr_idx] <= 1'b0;
            end
            if (do_write) begin
                valid[free_idx] <= 1'b1;
            end
        end
    end

    // Vehicle-number storage; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (do_write) begin
            vn_mem[free_idx] <= wr_vn;
        end
    end

endmodule
`default_nettype wire

// File: rtl/carpark_exit.sv
`default_nettype none
// ============================================================================
// Module      : carpark_exit
// Description : Exit-side car-park controller. Checks the exit password,
//               searches the slot table one slot per cycle, frees the
//               matching slot and holds the exit gate open.
//               Optional macro CARPARK_EXIT_LOCKOUT_EN adds a lockout after
//               three consecutive bad passwords.
// Revision    : 1.0 - initial release
// ============================================================================
module carpark_exit
    import carpark_pkg::*;
#(
    parameter  int              N_SLOTS     = 16,
    parameter  int              VN_W        = 4,
    parameter  int              PW_W        = 4,
    parameter  logic [PW_W-1:0] PASSWORD    = PW_W'(DEFAULT_PASSWORD),
    parameter  int              GATE_CYCLES = 4,
    localparam int              SLOT_W      = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entry_valid,
    input  logic [VN_W-1:0]   entry_vn,
    output logic              entry_ready,
    input  logic              exit_req,
    input  logic [VN_W-1:0]   exit_vn,
    input  logic [PW_W-1:0]   exit_pswd,
    output logic              exit_gate,
    output logic [SLOT_W-1:0] exit_slot,
    output logic              exit_done,
    output logic [1:0]        exit_err,
    output logic              busy,
    output logic [SLOT_W:0]   occupancy,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(max_int(GATE_CYCLES, LOCK_CYCLES) + 1);

    state_t            state, next_state;
    logic [VN_W-1:0]   vn_q;
    logic [PW_W-1:0]   pswd_q;
    logic [SLOT_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic              rd_valid;
    logic [VN_W-1:0]   rd_vn;
    logic              hit;
    logic              pswd_bad;
    logic              last_idx;
    logic              lock_trip;

    carpark_slot_table #(
        .N_SLOTS (N_SLOTS),
        .VN_W    (VN_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (entry_valid),
        .wr_vn     (entry_vn),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_vn     (rd_vn),
        .clr_en    (hit),
        .clr_idx   (idx),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign entry_ready = !full;
    assign hit         = (state == S_SEARCH) && rd_valid && (rd_vn == vn_q);
    assign pswd_bad    = (pswd_q != PASSWORD);
    assign last_idx    = (idx == SLOT_W'(N_SLOTS - 1));

`ifdef CARPARK_EXIT_LOCKOUT_EN
    logic [1:0] bad_cnt;

    assign lock_trip = pswd_bad && (bad_cnt == 2'd2);

    // Consecutive bad-password counter; any successful match clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cnt <= 2'd0;
        end else if (state == S_CHECK && pswd_bad) begin
            bad_cnt <= lock_trip ? 2'd0 : bad_cnt + 2'd1;
        end else if (hit) begin
            bad_cnt <= 2'd0;
        end
    end
`else
    assign lock_trip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (exit_req) next_state = S_CHECK;
            S_CHECK: begin
                if (pswd_bad)   next_state = lock_trip ? S_LOCK : S_ERR;
                else if (empty) next_state = S_ERR;
                else            next_state = S_SEARCH;
            end
            S_SEARCH: begin
                if (hit)           next_state = S_OPEN;
                else if (last_idx) next_state = S_ERR;
            end
            S_OPEN:   if (cnt == CNT_W'(1)) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            S_ERR:    next_state = S_IDLE;
            S_LOCK:   if (cnt == CNT_W'(1)) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        exit_gate = (state == S_OPEN);
        busy      = (state != S_IDLE);
        exit_done = (state == S_DONE) || (state == S_ERR) ||
                    ((state == S_LOCK) && (cnt == CNT_W'(1)));
    end

    // Request latches, search index, gate/lock timer and result registers;
    // exit_err is written on entry to ERR/LOCK so it is valid with exit_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_q      <= '0;
            pswd_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            exit_err  <= ERR_NONE;
            exit_slot <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exit_req) begin
                        vn_q     <= exit_vn;
                        pswd_q   <= exit_pswd;
                        exit_err <= ERR_NONE;
                    end
                end
                S_CHECK: begin
                    idx <= '0;
                    cnt <= CNT_W'(LOCK_CYCLES);
                    if (pswd_bad)   exit_err <= lock_trip ? ERR_LOCK : ERR_PSWD;
                    else if (empty) exit_err <= ERR_NOTFOUND;
                end
                S_SEARCH: begin
                    if (hit) begin
                        exit_slot <= idx;
                        cnt       <= CNT_W'(GATE_CYCLES);
                    end else if (last_idx) begin
                        exit_err  <= ERR_NOTFOUND;
                    end else begin
                        idx       <= idx + SLOT_W'(1);
                    end
                end
                S_OPEN, S_LOCK: cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
